// File: rtl/bus_cs_decoder_pkg.sv
// Shared widths and bus-cycle state encoding for the chip-select decoder.
package bus_cs_decoder_pkg;
  localparam int WAIT_W    = 3;
  localparam int IO_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    DATA = 3'd3
  } bus_state_t;
endpackage

// File: rtl/bus_cs_decoder_if.sv
// 8088 local-bus signals between the processor side (master) and the decoder (slave).
interface bus_cs_decoder_if #(
  parameter int ADDR_W      = 20,
  parameter int NUM_REGIONS = 4
);
  logic                   ale;
  logic                   iom;
  logic                   rd_n;
  logic                   wr_n;
  logic [ADDR_W-1:0]      addr_in;
  logic [ADDR_W-1:0]      addr_lat;
  logic [NUM_REGIONS-1:0] cs_n;
  logic                   ready;
  logic                   decode_err;

  modport master (
    output ale, iom, rd_n, wr_n, addr_in,
    input  addr_lat, cs_n, ready, decode_err
  );

  modport slave (
    input  ale, iom, rd_n, wr_n, addr_in,
    output addr_lat, cs_n, ready, decode_err
  );
endinterface

// File: rtl/bus_cs_decoder_wait_cnt.sv
// Wait-state down-counter: load W to hold ready low for exactly W cycles.
// ready is registered; last flags the final wait cycle so the FSM can advance with it.
module bus_cs_decoder_wait_cnt
  import bus_cs_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [WAIT_W-1:0] count,
  output logic              ready,
  output logic              last
);
  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ready <= 1'b1;
    end else if (abort) begin
      cnt   <= '0;
      ready <= 1'b1;
    end else if (load) begin
      cnt   <= count;
      ready <= (count == '0);
    end else if (cnt != '0) begin
      cnt <= cnt - WAIT_W'(1);
      if (cnt == WAIT_W'(1))
        ready <= 1'b1;
    end
  end

  assign last = (cnt == WAIT_W'(1));
endmodule

// File: rtl/bus_cs_decoder.sv
// Address latch, priority chip-select decode and wait-state FSM for an 8088 bus.
// Latch and CS_N valid one cycle after ALE; READY low for the hit region's wait count.
module bus_cs_decoder
  import bus_cs_decoder_pkg::*;
#(
  parameter int                            ADDR_W       = 20,
  parameter int                            NUM_REGIONS  = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK  = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0]        REGION_IS_IO = 4'b1100,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = {3'd1, 3'd2, 3'd0, 3'd0}
) (
  input logic              clk,
  input logic              rst_n,
  bus_cs_decoder_if.slave  bus
);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_ADDR = ADDR;
  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_DATA = DATA;

  localparam logic [ADDR_W-1:0] IO_KEEP = {{(ADDR_W-IO_ADDR_W){1'b0}}, {IO_ADDR_W{1'b1}}};

  logic [2:0]             state;
  logic [ADDR_W-1:0]      cmp;
  logic [NUM_REGIONS-1:0] hit_vec;
  logic [NUM_REGIONS-1:0] sel_onehot;
  logic [WAIT_W-1:0]      sel_wait;
  logic                   hit_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   strobe;
  logic                   both_low;
  logic                   both_low_q;
  logic                   cnt_load;
  logic                   cnt_abort;
  logic                   cnt_last;

  // Decode runs on the address being captured so CS_N lands together with ADDR_LAT.
  assign cmp = bus.iom ? (bus.addr_in & IO_KEEP) : bus.addr_in;

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    localparam logic [ADDR_W-1:0] BASE = REGION_BASE[k*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] MASK = REGION_MASK[k*ADDR_W +: ADDR_W];
    assign hit_vec[k] = ((cmp & MASK) == (BASE & MASK)) && (bus.iom == REGION_IS_IO[k]);
  end

  always_comb begin
    sel_onehot = '0;
    sel_wait   = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        sel_onehot    = '0;
        sel_onehot[k] = 1'b1;
        sel_wait      = REGION_WAIT[k*WAIT_W +: WAIT_W];
      end
    end
  end

  assign strobe   = !bus.rd_n || !bus.wr_n;
  assign both_low = !bus.rd_n && !bus.wr_n;

  assign cnt_load  = !bus.ale && (state == ST_ADDR) && hit_q && strobe;
  assign cnt_abort = bus.ale || ((state == ST_WAIT) && !strobe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bus.addr_lat   <= '0;
      bus.cs_n       <= '1;
      bus.decode_err <= 1'b0;
      hit_q          <= 1'b0;
      wait_q         <= '0;
      both_low_q     <= 1'b0;
    end else begin
      bus.decode_err <= 1'b0;
      both_low_q     <= both_low;
      if (bus.ale) begin
        state        <= ST_ADDR;
        bus.addr_lat <= bus.addr_in;
        bus.cs_n     <= ~sel_onehot;
        hit_q        <= |hit_vec;
        wait_q       <= sel_wait;
      end else begin
        case (state)
          ST_ADDR: begin
            if (!hit_q) begin
              state          <= ST_IDLE;
              bus.decode_err <= 1'b1;
            end else if (strobe) begin
              state <= (wait_q != '0) ? ST_WAIT : ST_DATA;
            end
          end
          ST_WAIT: begin
            if (!strobe) begin
              state    <= ST_IDLE;
              bus.cs_n <= '1;
            end else if (cnt_last) begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (!strobe) begin
              state    <= ST_IDLE;
              bus.cs_n <= '1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      // Conflicting strobes are flagged once per occurrence; the cycle carries on.
      if (both_low && !both_low_q && (state != ST_IDLE))
        bus.decode_err <= 1'b1;
    end
  end

  bus_cs_decoder_wait_cnt u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .abort (cnt_abort),
    .count (wait_q),
    .ready (bus.ready),
    .last  (cnt_last)
  );
endmodule
